// File: rtl/bash_msg_loader.sv
// bash_msg_loader -- message feeder for the bash hash core.
//
// Takes a byte-oriented stream of 32-bit words, packs it into RATE_W-bit blocks,
// appends the bash padding (0x40 followed by zeros) and hands each complete block
// to the absorb stage. One message is in flight at a time.
//
// Optional feature: define BASH_LOADER_LEN_EN to add the 64-bit msg_bytes length
// counter and its output port. Without it the port and the counter are absent.
//
// Ports
//   s_axi_aclk    clock, rising edge
//   s_axi_areset  synchronous active-high reset
//   in_data       message word, byte k at [8k+7:8k], byte 0 first
//   in_bytes      valid bytes in the word (1..4, 0 only together with in_last)
//   in_last       final word of the message
//   in_valid      word valid
//   in_ready      loader accepts a word (registered, depends on state only)
//   blk_data      block, word i at [32i+31:32i]
//   blk_last      block is the final, padded block of the message
//   blk_valid     block valid
//   blk_ready     absorb stage takes the block
//   msg_bytes     total message length in bytes (BASH_LOADER_LEN_EN only)
module bash_msg_loader #(
    parameter int SEC_LEVEL = 256
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_areset,
    input  logic [31:0]                   in_data,
    input  logic [2:0]                    in_bytes,
    input  logic                          in_last,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [1536-4*SEC_LEVEL-1:0]   blk_data,
    output logic                          blk_last,
    output logic                          blk_valid,
    input  logic                          blk_ready
`ifdef BASH_LOADER_LEN_EN
    ,output logic [63:0]                  msg_bytes
`endif
);
    localparam int RATE_W     = 1536 - 4*SEC_LEVEL;
    localparam int RATE_WORDS = RATE_W / 32;
    localparam int IDX_W      = $clog2(RATE_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_WORDS - 1);

    typedef enum logic [1:0] {FILL, PAD, OUT} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             pad_pending;  // block just emitted was full; a pad-only block follows
    logic [31:0]      word;

    // Incoming word with the unused bytes masked off. On the last word the first
    // unused byte carries the pad marker; a full last word leaves padding to PAD.
    always_comb begin
        word = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < in_bytes)
                word[8*b +: 8] = in_data[8*b +: 8];
            else if (in_last && 3'(b) == in_bytes)
                word[8*b +: 8] = 8'h40;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state       <= FILL;
            idx         <= '0;
            pad_pending <= 1'b0;
            in_ready    <= 1'b0;
            blk_data    <= '0;
            blk_last    <= 1'b0;
            blk_valid   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        // Buffer is zero outside written words, so no tail clearing needed.
                        blk_data[32*idx +: 32] <= word;
                        if (in_last && in_bytes != 3'd4) begin
                            state     <= OUT;
                            blk_valid <= 1'b1;
                            blk_last  <= 1'b1;
                            in_ready  <= 1'b0;
                        end else if (idx == LAST_IDX) begin
                            // Block full; if the message also ends here the pad
                            // goes into a separate block afterwards.
                            state       <= OUT;
                            blk_valid   <= 1'b1;
                            blk_last    <= 1'b0;
                            pad_pending <= in_last;
                            in_ready    <= 1'b0;
                        end else if (in_last) begin
                            idx      <= idx + 1'b1;
                            state    <= PAD;
                            in_ready <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                PAD: begin
                    blk_data[32*idx +: 32] <= 32'h0000_0040;
                    state       <= OUT;
                    blk_valid   <= 1'b1;
                    blk_last    <= 1'b1;
                    pad_pending <= 1'b0;
                end
                OUT: begin
                    if (blk_ready) begin
                        blk_data  <= '0;
                        idx       <= '0;
                        blk_valid <= 1'b0;
                        blk_last  <= 1'b0;
                        if (pad_pending) begin
                            state <= PAD;
                        end else begin
                            state    <= FILL;
                            in_ready <= 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef BASH_LOADER_LEN_EN
    logic [63:0] len_cnt;

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset)
            len_cnt <= '0;
        else if (state == FILL && in_valid && in_ready)
            len_cnt <= len_cnt + 64'(in_bytes);
        else if (blk_valid && blk_ready && blk_last)
            len_cnt <= '0;
    end

    assign msg_bytes = len_cnt;
`endif

endmodule
